// File: rtl/i2c_uart_tx_scheduler.sv
// Byte scheduler between the I2C slave receiver and the UART transmitter.
// I2C events are queued as bytes and fed to the UART one at a time, with an optional gap and a done-timeout.
module i2c_uart_tx_scheduler #(
  parameter int         DEPTH        = 8,
  parameter bit         EMIT_ADDR    = 1'b1,
  parameter bit         TERM_EN      = 1'b1,
  parameter logic [7:0] TERM_BYTE    = 8'h0A,
  parameter int         GAP_CLKS     = 0,
  parameter int         TIMEOUT_CLKS = 2048
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i2c_addr_valid,
  input  logic [6:0]               i2c_addr,
  input  logic                     i2c_rw,
  input  logic                     i2c_data_valid,
  input  logic [7:0]               i2c_data,
  input  logic                     i2c_stop,
  output logic                     i2c_nack,
  input  logic                     uart_tx_active,
  input  logic                     uart_tx_done,
  output logic                     uart_tx_start,
  output logic [7:0]               uart_tx_byte,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic                     tx_timeout,
  input  logic                     clear_flags
);
  localparam int AW   = $clog2(DEPTH);
  localparam int LW   = AW + 1;
  localparam int CMAX = (TIMEOUT_CLKS > GAP_CLKS) ? TIMEOUT_CLKS : GAP_CLKS;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [1:0]    state;
  logic [CW-1:0] cnt, cnt_inc;
  logic          data_seen;
  logic          push_req, push, pop, collide, timeout_hit;
  logic [7:0]    push_byte;
  logic [LW-1:0] level_next;

  // Only the highest-priority event of a collision is acted on.
  always_comb begin
    push_req  = 1'b0;
    push_byte = i2c_data;
    if (i2c_data_valid) begin
      push_req = 1'b1;
    end else if (i2c_addr_valid) begin
      push_req  = EMIT_ADDR;
      push_byte = {i2c_addr, i2c_rw};
    end else if (i2c_stop) begin
      push_req  = TERM_EN && data_seen;
      push_byte = TERM_BYTE;
    end
  end

  assign collide    = (i2c_data_valid & (i2c_addr_valid | i2c_stop)) | (i2c_addr_valid & i2c_stop);
  assign pop        = (state == S_IDLE) && (fifo_level != '0) && !uart_tx_active;
  assign push       = push_req && ((fifo_level != LW'(DEPTH)) || pop);
  assign level_next = fifo_level + LW'(push) - LW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      i2c_nack   <= 1'b0;
      data_seen  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
      i2c_nack   <= (level_next == LW'(DEPTH));
      if (i2c_data_valid)                 data_seen <= 1'b1;
      else if (i2c_addr_valid || i2c_stop) data_seen <= 1'b0;
      if (clear_flags)                          overflow <= 1'b0;
      else if (collide || (push_req && !push)) overflow <= 1'b1;
    end
  end

  // The counter holds clocks spent in WAIT minus one, so the flag lands TIMEOUT_CLKS clocks after start.
  assign cnt_inc       = cnt + CW'(1);
  assign timeout_hit   = (state == S_WAIT) && !uart_tx_done && (cnt_inc == CW'(TIMEOUT_CLKS - 1));
  assign uart_tx_start = (state == S_START);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      uart_tx_byte <= 8'h00;
      tx_timeout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (pop) begin
          uart_tx_byte <= mem[rd_ptr];
          state        <= S_START;
        end
        S_START: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (uart_tx_done) begin
            cnt   <= '0;
            state <= (GAP_CLKS > 0) ? S_GAP : S_IDLE;
          end else if (timeout_hit) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        S_GAP: begin
          if (cnt_inc >= CW'(GAP_CLKS)) state <= S_IDLE;
          else                          cnt   <= cnt_inc;
        end
        default: state <= S_IDLE;
      endcase
      if (clear_flags)      tx_timeout <= 1'b0;
      else if (timeout_hit) tx_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_uart_tx_scheduler.sv
// Bench for i2c_uart_tx_scheduler: a byte-level reference model feeds a scoreboard queue,
// and a monitor pops it on every uart_tx_start.
module tb_i2c_uart_tx_scheduler;
  localparam int         DEPTH = 8;
  localparam int         TO    = 32;
  localparam logic [7:0] TERM  = 8'h0A;

  logic clk = 1'b0, reset = 1'b1;
  logic i2c_addr_valid = 1'b0, i2c_rw = 1'b0, i2c_data_valid = 1'b0, i2c_stop = 1'b0;
  logic [6:0] i2c_addr = '0;
  logic [7:0] i2c_data = '0;
  logic i2c_nack, uart_tx_active, uart_tx_start, overflow, tx_timeout;
  logic uart_tx_done = 1'b0, clear_flags = 1'b0;
  logic [7:0] uart_tx_byte;
  logic [$clog2(DEPTH):0] fifo_level;

  logic m_active = 1'b0, hold = 1'b0, hang = 1'b0;
  int   uart_clks = 20;
  int   checks = 0, failures = 0;
  logic [7:0] exp_q [$];
  bit   exp_ovf = 0, seen = 0, nack_seen = 0;

  assign uart_tx_active = m_active | hold;
  always #5 clk = ~clk;

  i2c_uart_tx_scheduler #(.DEPTH(DEPTH), .EMIT_ADDR(1'b1), .TERM_EN(1'b1), .TERM_BYTE(TERM),
                          .GAP_CLKS(0), .TIMEOUT_CLKS(TO)) dut (
    .clk(clk), .reset(reset),
    .i2c_addr_valid(i2c_addr_valid), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw),
    .i2c_data_valid(i2c_data_valid), .i2c_data(i2c_data), .i2c_stop(i2c_stop),
    .i2c_nack(i2c_nack), .uart_tx_active(uart_tx_active), .uart_tx_done(uart_tx_done),
    .uart_tx_start(uart_tx_start), .uart_tx_byte(uart_tx_byte), .fifo_level(fifo_level),
    .overflow(overflow), .tx_timeout(tx_timeout), .clear_flags(clear_flags));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Reference: apply the winning event of a cycle to the expected byte stream.
  task automatic ev(input bit av, input bit dv, input bit sv, input logic [6:0] a,
                    input logic rw, input logic [7:0] d, input bit room);
    bit has;
    logic [7:0] b;
    has = 0; b = 8'h00;
    i2c_addr_valid = av; i2c_data_valid = dv; i2c_stop = sv;
    i2c_addr = a; i2c_rw = rw; i2c_data = d;
    if (dv) begin
      has = 1; b = d; seen = 1;
      if (av || sv) exp_ovf = 1;
    end else if (av) begin
      has = 1; b = {a, rw}; seen = 0;
      if (sv) exp_ovf = 1;
    end else if (sv) begin
      has = seen; b = TERM; seen = 0;
    end
    if (has) begin
      if (room) exp_q.push_back(b);
      else      exp_ovf = 1;
    end
    step();
    i2c_addr_valid = 0; i2c_data_valid = 0; i2c_stop = 0;
  endtask

  task automatic send_addr(input logic [6:0] a, input logic rw); ev(1, 0, 0, a, rw, 8'h00, 1); endtask
  task automatic send_data(input logic [7:0] d);                 ev(0, 1, 0, 7'h00, 0, d, 1); endtask
  task automatic send_stop();                                    ev(0, 0, 1, 7'h00, 0, 8'h00, 1); endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || uart_tx_active) && n < 5000) begin
      step();
      n++;
    end
    if (n >= 5000) begin
      checks++; failures++;
      $display("FAIL %s_drain: %0d bytes still pending, expected 0", name, exp_q.size());
    end
    repeat (2) step();
  endtask

  // Monitor: every start must present the next expected byte.
  always @(negedge clk) begin
    if (reset) begin
      if (i2c_nack) nack_seen = 1;
      if (uart_tx_start) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_start: got byte %0h expected no start", uart_tx_byte);
        end else begin
          check("tx_byte", uart_tx_byte, exp_q.pop_front());
        end
      end
    end
  end

  // UART model: busy for uart_clks after each start, then a one-cycle done.
  initial forever begin
    @(negedge clk);
    if (reset && uart_tx_start && !hang) begin
      @(posedge clk); #1 m_active = 1;
      repeat (uart_clks - 2) @(posedge clk);
      #1 uart_tx_done = 1; m_active = 0;
      @(posedge clk); #1 uart_tx_done = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int found;
    int n;
    #1 reset = 0;
    #1;
    check("rst_level", fifo_level, 0);
    check("rst_nack", i2c_nack, 0);
    check("rst_start", uart_tx_start, 0);
    check("rst_ovf", overflow, 0);
    check("rst_timeout", tx_timeout, 0);
    check("rst_byte", uart_tx_byte, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    step();

    // First-byte latency into an empty FIFO
    send_data(8'h5A);
    @(negedge clk);
    check("lat_level", fifo_level, 1);
    check("lat_start_early", uart_tx_start, 0);
    @(negedge clk);
    check("lat_start", uart_tx_start, 1);
    check("lat_level_after", fifo_level, 0);
    wait_drain("lat");

    // Write transaction
    nack_seen = 0; uart_clks = 20;
    send_addr(7'h47, 0);
    send_data(8'h67); send_data(8'h14); send_data(8'h1E);
    send_stop();
    wait_drain("write");
    check("write_ovf", overflow, 0);
    check("write_nack_never", nack_seen, 0);

    // Address-only transaction: no terminator
    send_addr(7'h47, 0);
    send_stop();
    wait_drain("addr_only");
    check("addr_only_level", fifo_level, 0);

    // Randomized transactions
    for (int t = 0; t < 25; t++) begin
      uart_clks = $urandom_range(3, 12);
      send_addr(7'($urandom), 1'($urandom));
      n = $urandom_range(0, 4);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) step();
        send_data(8'($urandom));
      end
      repeat ($urandom_range(0, 3)) step();
      send_stop();
      wait_drain("random");
    end
    check("random_ovf", overflow, exp_ovf);
    check("random_level", fifo_level, 0);

    // Fill with the UART held busy, then overflow
    hold = 1; uart_clks = 6;
    for (int i = 0; i < DEPTH; i++) send_data(8'h30 + 8'(i));
    @(negedge clk);
    check("full_level", fifo_level, DEPTH);
    check("full_nack", i2c_nack, 1);
    check("full_ovf_pre", overflow, 0);
    step();
    ev(0, 1, 0, 7'h00, 0, 8'hEE, 0);
    @(negedge clk);
    check("ovf_set", overflow, exp_ovf);
    check("ovf_level", fifo_level, DEPTH);
    step();
    clear_flags = 1; step(); clear_flags = 0; exp_ovf = 0;
    @(negedge clk);
    check("ovf_clear", overflow, 0);
    step();
    // Push and pop in the same cycle while full
    hold = 0;
    send_data(8'h77);
    @(negedge clk);
    check("pushpop_level", fifo_level, DEPTH);
    check("pushpop_ovf", overflow, 0);
    check("pushpop_nack", i2c_nack, 1);
    step();
    wait_drain("overflow");
    check("ovf_drain_nack", i2c_nack, 0);

    // Timeout: UART never answers
    hang = 1;
    send_data(8'hA1);
    send_data(8'hA2);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      if (uart_tx_start) found = 1;
    end
    check("to_first_start_found", found, 1);
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    check("to_not_yet", tx_timeout, 0);
    @(negedge clk);
    check("to_set", tx_timeout, 1);
    clear_flags = 1;
    @(posedge clk); #1 clear_flags = 0;
    @(negedge clk);
    check("to_next_start", uart_tx_start, 1);
    check("to_cleared", tx_timeout, 0);
    repeat (TO - 1) @(posedge clk);
    #1 clear_flags = 1;
    @(posedge clk); #1 clear_flags = 0;
    @(negedge clk);
    check("to_clear_priority", tx_timeout, 0);
    check("to_level", fifo_level, 0);
    hang = 0;
    step();
    wait_drain("timeout");

    // Collision, then reset while in WAIT with bytes queued
    uart_clks = 20;
    ev(0, 1, 1, 7'h00, 0, 8'hC1, 1);
    send_data(8'hC2); send_data(8'hC3); send_data(8'hC4);
    @(negedge clk);
    check("coll_ovf", overflow, exp_ovf);
    check("mid_level", fifo_level, 3);
    @(posedge clk); #1 reset = 0;
    #1;
    check("mid_rst_start", uart_tx_start, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_to", tx_timeout, 0);
    check("mid_rst_nack", i2c_nack, 0);
    exp_q.delete(); exp_ovf = 0; seen = 0;
    step();
    reset = 1;
    step();
    send_addr(7'h12, 1);
    send_data(8'h99);
    send_stop();
    wait_drain("post_reset");
    check("post_reset_ovf", overflow, exp_ovf);
    check("post_reset_level", fifo_level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
